fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
- Read-side consumer of the async FIFO, running entirely in the FIFO read clock domain.
- Pops WIDTH-bit entries using the FIFO's rinc/rempty/rdata interface and packs PACK consecutive entries into one wide word, little-endian.
- Presents each packed word downstream on a valid/ready handshake.
- A flush input emits a partially filled word early, with its entry count.

Parameters:
- WIDTH, 8: bit width of one FIFO entry (matches the FIFO data width).
- PACK, 4: number of entries per output word (PACK >= 2).
- CW, $clog2(PACK)+1: width of the entry-count output.

Ports:
- rclk  in  1  read-domain clock; the block's only clock.
- rrst_n  in  1  synchronous, active-low reset, sampled on rising rclk.
- rempty  in  1  FIFO empty flag; head entry is valid when low.
- rdata  in  WIDTH  FIFO head entry; valid whenever rempty=0.
- rinc  out  1  pop strobe to the FIFO; the FIFO advances on the rclk edge where rinc=1.
- flush  in  1  level request to emit the partial word.
- out_data  out  PACK*WIDTH  packed word; entry k occupies bits [k*WIDTH +: WIDTH].
- out_cnt  out  CW  number of valid entries in out_data (1..PACK).
- out_valid  out  1  out_data/out_cnt valid.
- out_ready  in  1  downstream accepts the word when out_valid&&out_ready.

Behaviour:
- Clock and reset: one clock, rclk. Reset rrst_n is synchronous and active-low.
- State FILL: collecting entries.
  - Lane counter cnt runs 0..PACK-1; entries are held in the internal buffer buf.
- State HOLD: out_valid=1. The word is held until accepted.
- rinc (combinational) = rrst_n && (state==FILL) && !rempty.
  - rinc is never asserted in HOLD or while rempty=1.
- On a FILL edge with rinc=1: buf lane cnt <= rdata.
  - If cnt==PACK-1: out_data <= buf with the new lane, out_cnt <= PACK, out_valid <= 1, cnt <= 0, state <= HOLD.
  - Else if flush=1: emit buf plus the new lane, out_cnt <= cnt+1, go to HOLD, cnt <= 0. The popped entry is included.
  - Else: cnt <= cnt+1.
- On a FILL edge with rinc=0 and flush=1:
  - If cnt>0: emit buf, out_cnt <= cnt, go to HOLD, cnt <= 0.
  - If cnt==0: ignore the flush; no output.
- Partial words: unused lanes of out_data are driven to 0. buf lanes are cleared when a word is emitted.
- HOLD:
  - out_data and out_cnt stay stable while out_valid && !out_ready.
  - flush is ignored in HOLD.
  - On out_ready=1: out_valid <= 0, state <= FILL. No pop occurs in that same cycle.
- Latency and throughput:
  - out_valid rises on the edge that pops the last entry of a word.
  - Peak throughput is one word per PACK+1 cycles.
- Reset (rrst_n=0 at a rising rclk):
  - state=FILL, cnt=0, buf=0, out_data=0, out_cnt=0, out_valid=0.
  - rinc=0 while rrst_n=0.
  - Reset mid-fill or mid-hold discards partial or pending data; no entry is popped during reset.
- FIFO empty mid-word: stall in FILL holding cnt. There is no timeout; only flush forces output.
- FIFO full: no special handling. The block drains whenever it is in FILL.

Test Plan:
1. WIDTH=8, PACK=4. Write 0x11,0x22,0x33,0x44 into the FIFO, out_ready=1 -> four rinc pulses; out_data=0x44332211, out_cnt=4, out_valid high for one cycle.
2. Write 8 entries 0x11..0x88 with out_ready=0 -> first word 0x44332211 held stable, rinc=0, four entries remain in the FIFO. Raise out_ready -> second word 0x88776655 follows.
3. Write 0xAA,0xBB, wait until rempty=1, pulse flush -> out_data=0x0000BBAA, out_cnt=2. Then 0xC1..0xC4 -> 0xC4C3C2C1, out_cnt=4.
4. flush asserted on the cycle popping the 3rd entry 0x03 after 0x01,0x02 -> out_data=0x00030201, out_cnt=3. flush with cnt=0 and FIFO empty -> no out_valid.
5. Pop 0x01,0x02, then rrst_n=0 for one cycle -> out_valid=0, cnt=0, no pop during reset. Next entries 0x10,0x20,0x30,0x40 -> 0x40302010.
6. Sporadic writes with rempty toggling -> rinc asserted only in cycles where rempty=0. Word contents match write order exactly, with no duplicates or drops.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Read-domain FIFO consumer: pops WIDTH-bit entries and packs PACK of them
// little-endian into one wide word, presented on a valid/ready handshake.
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4,
  parameter int CW    = $clog2(PACK) + 1
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  rinc,
  input  logic                  flush,
  output logic [PACK*WIDTH-1:0] out_data,
  output logic [CW-1:0]         out_cnt,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int LW = $clog2(PACK);
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]            state_reg, state_next;
  logic [LW-1:0]         cnt_reg, cnt_next;
  logic [PACK*WIDTH-1:0] buf_reg, buf_next, merged;
  logic [PACK*WIDTH-1:0] out_data_reg, out_data_next;
  logic [CW-1:0]         out_cnt_reg, out_cnt_next;
  logic                  in_fill, last_lane;
  logic                  emit_full, emit_flush_pop, emit_flush_idle, emit;

  assign in_fill   = (state_reg == ST_FILL);
  assign rinc      = rrst_n && in_fill && !rempty;
  assign last_lane = (cnt_reg == LW'(PACK - 1));

  // Buffer contents with the entry being popped this cycle dropped into its lane.
  genvar gi;
  generate
    for (gi = 0; gi < PACK; gi++) begin : g_lane
      assign merged[gi*WIDTH +: WIDTH] =
        (rinc && (cnt_reg == LW'(gi))) ? rdata : buf_reg[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign emit_full       = rinc && last_lane;
  assign emit_flush_pop  = rinc && !last_lane && flush;
  assign emit_flush_idle = !rinc && in_fill && flush && (cnt_reg != '0);
  assign emit            = emit_full || emit_flush_pop || emit_flush_idle;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    buf_next      = merged;
    out_data_next = out_data_reg;
    out_cnt_next  = out_cnt_reg;
    if (emit) begin
      // Emitted lanes are cleared so the next partial word has zero-filled upper lanes.
      buf_next      = '0;
      out_data_next = merged;
      cnt_next      = '0;
      state_next    = ST_HOLD;
      if (emit_full)
        out_cnt_next = CW'(PACK);
      else if (emit_flush_pop)
        out_cnt_next = CW'(cnt_reg) + CW'(1);
      else
        out_cnt_next = CW'(cnt_reg);
    end else if (rinc) begin
      cnt_next = cnt_reg + LW'(1);
    end else if (!in_fill && out_ready) begin
      state_next = ST_FILL;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_reg    <= ST_FILL;
      cnt_reg      <= '0;
      buf_reg      <= '0;
      out_data_reg <= '0;
      out_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      buf_reg      <= buf_next;
      out_data_reg <= out_data_next;
      out_cnt_reg  <= out_cnt_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_cnt   = out_cnt_reg;
  assign out_valid = (state_reg == ST_HOLD);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: emulates the FIFO with a queue and predicts words
// from the list of popped entries, flush requests and handshakes.
module tb_fifo_rd_packer;
  localparam int WIDTH = 8;
  localparam int PACK  = 4;
  localparam int CW    = 3;

  logic                  rclk = 1'b0;
  logic                  rrst_n = 1'b0;
  logic                  rempty = 1'b1;
  logic [WIDTH-1:0]      rdata = '0;
  logic                  rinc;
  logic                  flush = 1'b0;
  logic [PACK*WIDTH-1:0] out_data;
  logic [CW-1:0]         out_cnt;
  logic                  out_valid;
  logic                  out_ready = 1'b0;

  always #5 rclk = ~rclk;

  fifo_rd_packer #(.WIDTH(WIDTH), .PACK(PACK), .CW(CW)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .flush(flush), .out_data(out_data), .out_cnt(out_cnt), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  logic [WIDTH-1:0]      fifo_q[$];
  logic [WIDTH-1:0]      pend_q[$];
  bit                    hold_m = 1'b0;
  bit                    after_rst = 1'b0;
  logic [PACK*WIDTH-1:0] word_m = '0;
  int                    cnt_m = 0;
  int                    checks = 0;
  int                    passes = 0;
  int                    words = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  // One clock cycle: apply inputs, check outputs against the model, advance the model.
  task automatic step(input bit push, input logic [WIDTH-1:0] val, input bit fl,
                      input bit rdy, input bit rst);
    bit               rinc_exp;
    bit               popped;
    logic [WIDTH-1:0] head;
    @(negedge rclk);
    if (push) fifo_q.push_back(val);
    rempty    = (fifo_q.size() == 0);
    rdata     = rempty ? '0 : fifo_q[0];
    flush     = fl;
    out_ready = rdy;
    rrst_n    = !rst;
    #1;
    rinc_exp = !rst && !hold_m && (fifo_q.size() != 0);
    check_val("rinc", {63'd0, rinc}, {63'd0, rinc_exp});
    check_val("out_valid", {63'd0, out_valid}, {63'd0, hold_m});
    if (after_rst) begin
      check_val("rst_out_data", 64'(out_data), 64'd0);
      check_val("rst_out_cnt", 64'(out_cnt), 64'd0);
    end
    if (hold_m && out_valid) begin
      check_val("out_data", 64'(out_data), 64'(word_m));
      check_val("out_cnt", 64'(out_cnt), 64'(cnt_m));
    end
    popped = rinc;
    head   = rdata;
    @(posedge rclk);
    if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
    after_rst = rst;
    if (rst) begin
      pend_q.delete();
      hold_m = 1'b0;
    end else if (hold_m) begin
      if (rdy) begin
        hold_m = 1'b0;
        words++;
      end
    end else begin
      if (rinc_exp) pend_q.push_back(head);
      if (pend_q.size() == PACK || (fl && pend_q.size() > 0)) begin
        word_m = '0;
        foreach (pend_q[k]) word_m |= (PACK*WIDTH)'(pend_q[k]) << (WIDTH * k);
        cnt_m = pend_q.size();
        pend_q.delete();
        hold_m = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Single full word with downstream always ready.
    step(1, 8'h11, 0, 1, 0); step(1, 8'h22, 0, 1, 0);
    step(1, 8'h33, 0, 1, 0); step(1, 8'h44, 0, 1, 0);
    idle(6, 1'b1);

    // Back-pressure: second word waits in the FIFO until the first is accepted.
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i * 8'h11), 1'b0, 1'b0, 1'b0);
    idle(6, 1'b0);
    idle(12, 1'b1);

    // Flush after the FIFO runs dry, then a full word.
    step(1, 8'hAA, 0, 1, 0); step(1, 8'hBB, 0, 1, 0);
    idle(4, 1'b1);
    step(0, 8'h00, 1, 0, 0);
    idle(3, 1'b0);
    idle(2, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Flush on the edge that pops the third entry; then a flush with nothing buffered.
    step(1, 8'h01, 0, 1, 0); step(1, 8'h02, 0, 1, 0); step(1, 8'h03, 1, 1, 0);
    idle(3, 1'b1);
    step(0, 8'h00, 1, 1, 0);
    idle(3, 1'b1);

    // Reset mid-fill discards the partial word.
    step(1, 8'h01, 0, 1, 0); step(1, 8'h02, 0, 1, 0);
    step(0, 8'h00, 0, 1, 1);
    step(1, 8'h10, 0, 1, 0); step(1, 8'h20, 0, 1, 0);
    step(1, 8'h30, 0, 1, 0); step(1, 8'h40, 0, 1, 0);
    idle(6, 1'b1);

    // Random traffic: sporadic writes, flushes, back-pressure and rare resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 40), 8'($urandom), ($urandom_range(0, 99) < 6),
           ($urandom_range(0, 99) < 60), ($urandom_range(0, 999) < 4));
    end
    idle(20, 1'b1);

    check_val("words_seen_nonzero", {63'd0, (words > 10)}, 64'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
